// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result and shared-adder bus for bcd_serial_add_ctrl.
// The slave modport is the sequencer. The master modport is the requester
// together with the external 4-bit adder.
interface bcd_serial_add_ctrl_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   op_a;
    logic [4*DIGITS-1:0]   op_b;
    logic                  c_in;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  c_out;
    logic                  err;
    logic [3:0]            add_a;
    logic [3:0]            add_b;
    logic                  add_cin;
    logic [3:0]            add_s;
    logic                  add_cout;

    modport slave (
        input  start, op_a, op_b, c_in, add_s, add_cout,
        output busy, done, sum, c_out, err, add_a, add_b, add_cin
    );

    modport master (
        output start, op_a, op_b, c_in, add_s, add_cout,
        input  busy, done, sum, c_out, err, add_a, add_b, add_cin
    );
endinterface

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer driving one shared 4-bit binary adder.
// Each digit takes one raw-add pass, plus a +6 correction pass when the raw
// result exceeds 9.
// Optional feature: define BCD_CHECK_EN to flag non-BCD operand digits on err.
module bcd_serial_add_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_serial_add_ctrl_if.slave bus
);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W     = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, ADD, CORR, DONE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry_q;
    logic [3:0]       raw_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     sum_q;
    logic             c_out_q;
    logic             last_digit;
    logic             corr_needed;

    // A raw digit result above 9 (including a binary carry-out) needs +6.
    function automatic logic needs_corr(input logic cout, input logic [3:0] s);
        return cout | (s > 4'd9);
    endfunction

`ifdef BCD_CHECK_EN
    logic err_q;

    // True when any digit of either operand lies in A..F.
    function automatic logic has_non_bcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign last_digit  = (idx == IDX_W'(DIGITS - 1));
    assign corr_needed = needs_corr(bus.add_cout, bus.add_s);
    assign bus.sum     = sum_q;
    assign bus.c_out   = c_out_q;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: raw add, optional correction, advance or finish.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = ADD;
            ADD: begin
                if (corr_needed)     state_nxt = CORR;
                else if (last_digit) state_nxt = DONE;
                else                 state_nxt = ADD;
            end
            CORR:    state_nxt = last_digit ? DONE : ADD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: status flags and the operands steered to the shared adder.
    always_comb begin
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        bus.add_a   = 4'd0;
        bus.add_b   = 4'd0;
        bus.add_cin = 1'b0;
        case (state)
            IDLE: bus.busy = 1'b0;
            ADD: begin
                bus.add_a   = a_q[idx*4 +: 4];
                bus.add_b   = b_q[idx*4 +: 4];
                bus.add_cin = carry_q;
            end
            CORR: begin
                bus.add_a = raw_q;
                bus.add_b = 4'd6;
            end
            DONE:    bus.done = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

    // Control and result registers: digit index, decimal carry, sum, carry-out, err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef BCD_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx     <= '0;
                        carry_q <= bus.c_in;
                        sum_q   <= '0;
                        c_out_q <= 1'b0;
`ifdef BCD_CHECK_EN
                        err_q   <= has_non_bcd(bus.op_a, bus.op_b);
`endif
                    end
                end
                ADD: begin
                    if (!corr_needed) begin
                        sum_q[idx*4 +: 4] <= bus.add_s;
                        carry_q           <= 1'b0;
                        if (last_digit) c_out_q <= 1'b0;
                        else            idx     <= idx + IDX_W'(1);
                    end
                end
                CORR: begin
                    sum_q[idx*4 +: 4] <= bus.add_s;
                    carry_q           <= 1'b1;
                    if (last_digit) c_out_q <= 1'b1;
                    else            idx     <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Operand and raw-digit holding registers; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            a_q <= bus.op_a;
            b_q <= bus.op_b;
        end
        if (state == ADD) begin
            raw_q <= bus.add_s;
        end
    end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4) with a behavioural 4-bit adder.
module tb_bcd_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [3:0] trace_b   [0:31];
    logic       trace_cin [0:31];
`ifdef BCD_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    bcd_serial_add_ctrl_if #(.DIGITS(4)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Shared external ripple adder.
    assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One operation; lat counts cycles from the accepting edge to the done cycle.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                          input int exp_lat, input logic [31:0] pmask, input logic exp_err);
        int k;
        @(negedge clk);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.c_in  = cin;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = ~a;
        bus.op_b  = ~b;
        k = 1;
        chk({nm, ".busy"}, 32'(bus.busy), 32'd1);
        chk({nm, ".err_latch"}, 32'(bus.err), 32'(exp_err));
        while (k < 30) begin
            trace_b[k-1]   = bus.add_b;
            trace_cin[k-1] = bus.add_cin;
            bus.start      = pmask[k];
            if (bus.done) break;
            @(posedge clk);
            #1;
            k++;
        end
        chk({nm, ".latency"}, 32'(k), 32'(exp_lat));
        chk({nm, ".sum"}, 32'(bus.sum), 32'(exp_sum));
        chk({nm, ".c_out"}, 32'(bus.c_out), 32'(exp_cout));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk({nm, ".done_pulse"}, 32'(bus.done), 32'd0);
        chk({nm, ".idle"}, 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        chk({nm, ".stay_idle"}, 32'(bus.busy), 32'd0);
        chk({nm, ".sum_held"}, 32'(bus.sum), 32'(exp_sum));
        chk({nm, ".err"}, 32'(bus.err), 32'(exp_err));
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.c_in  = 1'b0;
        #2;
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.sum", 32'(bus.sum), 32'd0);
        chk("rst.c_out", 32'(bus.c_out), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        chk("rst.add_a", 32'(bus.add_a), 32'd0);
        chk("rst.add_b", 32'(bus.add_b), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 5, 32'd0, 1'b0);
        chk("t1.first_b", 32'(trace_b[0]), 32'd1);
        run_op("t2", 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 8, 32'd0, 1'b0);
        run_op("t3", 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 9, 32'd0, 1'b0);
        chk("t3.first_cin", 32'(trace_cin[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("t3.corr_b", 32'(trace_b[2*i+1]), 32'd6);
            chk("t3.corr_cin", 32'(trace_cin[2*i+1]), 32'd0);
        end
        // Stray starts in cycle 2 (ADD) and cycle 5 (DONE) are ignored.
        run_op("t4", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 5, 32'h0000_0024, 1'b0);
        run_op("t_cin", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 5, 32'd0, 1'b0);
        run_op("t_one_corr", 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 6, 32'd0, 1'b0);

        // Reset during the ADD pass of digit 2.
        @(negedge clk);
        bus.op_a  = 16'h1111;
        bus.op_b  = 16'h1111;
        bus.c_in  = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t5.partial", 32'(bus.sum), 32'h0022);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.busy", 32'(bus.busy), 32'd0);
        chk("t5.sum", 32'(bus.sum), 32'd0);
        chk("t5.c_out", 32'(bus.c_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("t5.after", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 5, 32'd0, 1'b0);

        run_op("t6.bad", 16'h00A1, 16'h0000, 1'b0, 16'h0101, 1'b0, 6, 32'd0, ERR_EN);
        run_op("t6.good", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 5, 32'd0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1);
    end
endmodule
